// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default configuration for the PLL reset controller.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } pll_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 64;
  localparam int DEF_DIV           = 8;
  localparam int DEF_CNT_W         = 8;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pll_rst_ctrl_sync_ff.sv
// N-stage single-bit synchronizer; async active-low reset clears the chain to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic RST_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n)
          chain_reg[gi] <= 1'b0;
        else if (gi == 0)
          chain_reg[gi] <= d;
        else
          chain_reg[gi] <= chain_reg[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// Holds the core in reset until the PLL lock has been stable for a full window.
// Optional macro PLL_LOSS_STICKY_EN makes a lock loss terminal until RST_n.
module pll_rst_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int DIV           = DEF_DIV,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             locked,
  output logic             rst_out_n,
  output logic             ready,
  output logic             en_strobe,
  output logic [CNT_W-1:0] loss_cnt,
  output logic             fault
);

  localparam int STAB_W = cnt_width(STABLE_CYCLES);
  localparam int DIV_W  = cnt_width(DIV);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);

  logic lock_s;

  pll_state_t        state_reg, state_next;
  logic [STAB_W-1:0] stab_cnt_reg, stab_cnt_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic              rst_out_n_reg, rst_out_n_next;
  logic              ready_reg, ready_next;
  logic              en_strobe_reg, en_strobe_next;
  logic [CNT_W-1:0]  loss_cnt_reg, loss_cnt_next;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .RST_n (RST_n),
    .d     (locked),
    .q     (lock_s)
  );

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_reg     <= WAIT_LOCK;
      stab_cnt_reg  <= '0;
      div_cnt_reg   <= '0;
      rst_out_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
      en_strobe_reg <= 1'b0;
      loss_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      stab_cnt_reg  <= stab_cnt_next;
      div_cnt_reg   <= div_cnt_next;
      rst_out_n_reg <= rst_out_n_next;
      ready_reg     <= ready_next;
      en_strobe_reg <= en_strobe_next;
      loss_cnt_reg  <= loss_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    stab_cnt_next  = stab_cnt_reg;
    div_cnt_next   = div_cnt_reg;
    rst_out_n_next = rst_out_n_reg;
    ready_next     = ready_reg;
    en_strobe_next = 1'b0;
    loss_cnt_next  = loss_cnt_reg;

    case (state_reg)
      WAIT_LOCK: begin
        stab_cnt_next = '0;
        if (lock_s)
          state_next = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s) begin
          // Any dropout restarts the whole stabilization window.
          state_next    = WAIT_LOCK;
          stab_cnt_next = '0;
        end else if (stab_cnt_reg == STAB_LAST) begin
          state_next     = RUN;
          rst_out_n_next = 1'b1;
          ready_next     = 1'b1;
          div_cnt_next   = '0;
        end else begin
          stab_cnt_next = stab_cnt_reg + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next     = LOST;
          rst_out_n_next = 1'b0;
          ready_next     = 1'b0;
          div_cnt_next   = '0;
          if (loss_cnt_reg != '1)
            loss_cnt_next = loss_cnt_reg + 1'b1;
        end else begin
          // Strobe is registered, so it lands one edge after the terminal count.
          en_strobe_next = (div_cnt_reg == DIV_LAST);
          div_cnt_next   = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
        end
      end
      LOST: begin
`ifdef PLL_LOSS_STICKY_EN
        state_next = LOST;
`else
        state_next    = WAIT_LOCK;
        stab_cnt_next = '0;
`endif
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

`ifdef PLL_LOSS_STICKY_EN
  logic fault_reg;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n)
      fault_reg <= 1'b0;
    else if (state_reg == RUN && !lock_s)
      fault_reg <= 1'b1;
  end

  assign fault = fault_reg;
`else
  assign fault = 1'b0;
`endif

  assign rst_out_n = rst_out_n_reg;
  assign ready     = ready_reg;
  assign en_strobe = en_strobe_reg;
  assign loss_cnt  = loss_cnt_reg;

endmodule
